// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned RegAddrW = 4;
  localparam int unsigned PerfCntW = 16;

  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [1:0]          fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'b00;
  localparam fwd_sel_t FWD_WB   = 2'b01;
  localparam fwd_sel_t FWD_MEM  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one execute-stage source register.
module fwd_sel
  import hazard_pkg::*;
(
  input  reg_addr_t src,
  input  reg_addr_t dst_m,
  input  reg_addr_t dst_w,
  input  logic      we_m,
  input  logic      we_w,
  output fwd_sel_t  sel
);

  // Memory stage holds the younger result, so it wins on a double match.
  always_comb begin
    sel = FWD_NONE;
    if (we_m && (src == dst_m)) begin
      sel = FWD_MEM;
    end else if (we_w && (src == dst_w)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use stall and PC-write tracking.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [RegAddrW-1:0] RA1D,
  input  logic [RegAddrW-1:0] RA2D,
  input  logic [RegAddrW-1:0] RA1E,
  input  logic [RegAddrW-1:0] RA2E,
  input  logic [RegAddrW-1:0] writeAdressE,
  input  logic [RegAddrW-1:0] writeAdressM,
  input  logic [RegAddrW-1:0] writeAdressW,
  input  logic                RegWM,
  input  logic                RegWW,
  input  logic                MemtoRegE,
  input  logic                PCSD,
  input  logic                branchTakenE,
`ifdef HAZARD_PERF_CNT_EN
  input  logic                perf_clr,
  output logic [PerfCntW-1:0] stall_cnt,
  output logic [PerfCntW-1:0] flush_cnt,
`endif
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE,
  output logic                StallF,
  output logic                StallD,
  output logic                FlushD,
  output logic                FlushE
);

  fwd_sel_t fwd_a, fwd_b;
  logic     ldr_stall, flush_e;
  logic     pcs_e_d, pcs_e_q, pcs_m_q, pcs_w_q;

  fwd_sel u_fwd_a (
    .src   (RA1E),
    .dst_m (writeAdressM),
    .dst_w (writeAdressW),
    .we_m  (RegWM),
    .we_w  (RegWW),
    .sel   (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src   (RA2E),
    .dst_m (writeAdressM),
    .dst_w (writeAdressW),
    .we_m  (RegWM),
    .we_w  (RegWW),
    .sel   (fwd_b)
  );

  always_comb begin
    ldr_stall = MemtoRegE && ((RA1D == writeAdressE) || (RA2D == writeAdressE));
    flush_e   = ldr_stall || branchTakenE;
    // A flushed decode/execute register must not carry a PC write forward.
    pcs_e_d   = flush_e ? 1'b0 : PCSD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcs_e_q <= 1'b0;
      pcs_m_q <= 1'b0;
      pcs_w_q <= 1'b0;
    end else begin
      pcs_e_q <= pcs_e_d;
      pcs_m_q <= pcs_e_q;
      pcs_w_q <= pcs_m_q;
    end
  end

  always_comb begin
    ForwardAE = reset ? fwd_a : FWD_NONE;
    ForwardBE = reset ? fwd_b : FWD_NONE;
    StallF    = ldr_stall || PCSD || pcs_e_q || pcs_m_q;
    StallD    = ldr_stall;
    FlushD    = PCSD || pcs_e_q || pcs_m_q || pcs_w_q || branchTakenE;
    FlushE    = flush_e;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PerfCntW-1:0] stall_cnt_d, stall_cnt_q;
  logic [PerfCntW-1:0] flush_cnt_d, flush_cnt_q;

  // Saturating counters; clear overrides any increment in the same cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (ldr_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_e && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E;
  logic [3:0] writeAdressE, writeAdressM, writeAdressW;
  logic       RegWM, RegWW, MemtoRegE, PCSD, branchTakenE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE;
`ifdef HAZARD_PERF_CNT_EN
  logic        perf_clr;
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .writeAdressE (writeAdressE),
    .writeAdressM (writeAdressM),
    .writeAdressW (writeAdressW),
    .RegWM        (RegWM),
    .RegWW        (RegWW),
    .MemtoRegE    (MemtoRegE),
    .PCSD         (PCSD),
    .branchTakenE (branchTakenE),
`ifdef HAZARD_PERF_CNT_EN
    .perf_clr     (perf_clr),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control bundle packed as {StallF, StallD, FlushD, FlushE}.
  function automatic logic [15:0] ctl();
    return {12'h0, StallF, StallD, FlushD, FlushE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    writeAdressE = 4'd9; writeAdressM = 4'd10; writeAdressW = 4'd11;
    RegWM = 1'b0; RegWW = 1'b0; MemtoRegE = 1'b0; PCSD = 1'b0; branchTakenE = 1'b0;
  endtask

  initial begin
    idle_inputs();
`ifdef HAZARD_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    reset = 1'b0;
    // Forwarding match presented during reset must be masked.
    RegWM = 1'b1; writeAdressM = 4'd3; RA1E = 4'd3;
    #3;
    check_eq("rst_fwd_a", {14'h0, ForwardAE}, 16'h0);
    check_eq("rst_ctl", ctl(), 16'h0);
    tick();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();

    // Forwarding priority.
    RegWM = 1'b1; writeAdressM = 4'd3; RA1E = 4'd3; RegWW = 1'b1; writeAdressW = 4'd3;
    #1 check_eq("fwd_a_mem", {14'h0, ForwardAE}, 16'h2);
    RegWM = 1'b0;
    #1 check_eq("fwd_a_wb", {14'h0, ForwardAE}, 16'h1);
    RA1E = 4'd4;
    #1 check_eq("fwd_a_none", {14'h0, ForwardAE}, 16'h0);
    RA2E = 4'hF; writeAdressW = 4'hF; RegWW = 1'b1; writeAdressM = 4'hF; RegWM = 1'b0;
    #1 check_eq("fwd_b_wb_f", {14'h0, ForwardBE}, 16'h1);
    RegWM = 1'b1;
    #1 check_eq("fwd_b_mem_f", {14'h0, ForwardBE}, 16'h2);
    RA2E = 4'd7;
    #1 check_eq("fwd_b_none", {14'h0, ForwardBE}, 16'h0);
    check_eq("fwd_ctl_quiet", ctl(), 16'h0);
    idle_inputs();

    // Load-use stall on either source.
    MemtoRegE = 1'b1; writeAdressE = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    #1 check_eq("ldr_b", ctl(), 16'b1101);
    tick();
    MemtoRegE = 1'b0;
    #1 check_eq("ldr_clear", ctl(), 16'b0000);
    MemtoRegE = 1'b1; RA1D = 4'd5; RA2D = 4'd2;
    #1 check_eq("ldr_a", ctl(), 16'b1101);
    writeAdressE = 4'd6;
    #1 check_eq("ldr_nomatch", ctl(), 16'b0000);
    idle_inputs();
    tick();

    // PC write walks through the tracker.
    PCSD = 1'b1;
    #1 check_eq("pcs_d", ctl(), 16'b1010);
    tick(); PCSD = 1'b0;
    #1 check_eq("pcs_e", ctl(), 16'b1010);
    tick();
    check_eq("pcs_m", ctl(), 16'b1010);
    tick();
    check_eq("pcs_w", ctl(), 16'b0010);
    tick();
    check_eq("pcs_done", ctl(), 16'b0000);

    // PC write cancelled by a taken branch.
    PCSD = 1'b1; branchTakenE = 1'b1;
    #1 check_eq("pcs_br", ctl(), 16'b1011);
    tick(); PCSD = 1'b0; branchTakenE = 1'b0;
    #1 check_eq("pcs_br_next", ctl(), 16'b0000);

    // Load-use stall coinciding with a taken branch.
    MemtoRegE = 1'b1; writeAdressE = 4'd2; RA1D = 4'd2; branchTakenE = 1'b1;
    #1 check_eq("ldr_br", ctl(), 16'b1111);
    tick(); idle_inputs();
    #1 check_eq("ldr_br_next", ctl(), 16'b0000);

    // Asynchronous reset with pcsM set.
    PCSD = 1'b1;
    tick(); PCSD = 1'b0;
    tick();
    check_eq("pre_rst_m", ctl(), 16'b1010);
    RegWM = 1'b1; writeAdressM = 4'd8; RA2E = 4'd8;
    #2 reset = 1'b0;
    #1 check_eq("async_rst_ctl", ctl(), 16'b0000);
    check_eq("async_rst_fwd_b", {14'h0, ForwardBE}, 16'h0);
    tick();
    check_eq("rst_hold_ctl", ctl(), 16'b0000);
    PCSD = 1'b1;
    #1 reset = 1'b1;
    #1 check_eq("pcs_d_after_rst", ctl(), 16'b1010);
    check_eq("fwd_b_after_rst", {14'h0, ForwardBE}, 16'h2);
    tick(); PCSD = 1'b0;
    #1 check_eq("pcs_e_after_rst", ctl(), 16'b1010);
    tick(); tick();
    check_eq("pcs_w_after_rst", ctl(), 16'b0010);
    idle_inputs();
    tick();

`ifdef HAZARD_PERF_CNT_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check_eq("perf_clr0", stall_cnt, 16'h0);
    MemtoRegE = 1'b1; writeAdressE = 4'd4; RA1D = 4'd4;
    repeat (5) tick();
    check_eq("stall_cnt5", stall_cnt, 16'd5);
    check_eq("flush_cnt5", flush_cnt, 16'd5);
    repeat (70000) @(posedge clk);
    #1 check_eq("stall_sat", stall_cnt, 16'hFFFF);
    check_eq("flush_sat", flush_cnt, 16'hFFFF);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check_eq("stall_clr", stall_cnt, 16'h0);
    check_eq("flush_clr", flush_cnt, 16'h0);
    idle_inputs();
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
